// File: rtl/regfile_pkg.sv
// Shared constants and helpers for the multi-port register file.
package regfile_pkg;

   localparam int REGFILE_DATA_W   = 32;
   localparam int REGFILE_NUM_REGS = 32;
   localparam int ZERO_ADDR        = 0;

   function automatic int clog2(input int n);
      int r;
      r = 0;
      while ((1 << r) < n) r++;
      return r;
   endfunction

endpackage

// File: rtl/regfile_mp_if.sv
// Read/write/issue bus of the register file; the datapath is master, the regfile is slave.
interface regfile_mp_if
   import regfile_pkg::*;
#(
   parameter int DATA_W   = REGFILE_DATA_W,
   parameter int NUM_REGS = REGFILE_NUM_REGS,
   parameter int NUM_READ = 2
);
   localparam int ADDR_W = clog2(NUM_REGS);

   logic [NUM_READ-1:0][ADDR_W-1:0] rs_addr;
   logic [NUM_READ-1:0][DATA_W-1:0] rs_data;
   logic [NUM_READ-1:0]             rs_busy;
   logic                            reg_write;
   logic [ADDR_W-1:0]               rd;
   logic [DATA_W-1:0]               data_in;
   logic                            issue_valid;
   logic [ADDR_W-1:0]               issue_rd;

   modport master (
      output rs_addr, reg_write, rd, data_in, issue_valid, issue_rd,
      input  rs_data, rs_busy
   );

   modport slave (
      input  rs_addr, reg_write, rd, data_in, issue_valid, issue_rd,
      output rs_data, rs_busy
   );
endinterface

// File: rtl/regfile_scoreboard.sv
// Per-register busy bits for RAW hazard detection, plus per-port busy lookup.
module regfile_scoreboard
   import regfile_pkg::*;
#(
   parameter int NUM_REGS    = REGFILE_NUM_REGS,
   parameter int NUM_READ    = 2,
   parameter bit ZERO_REG_EN = 1'b1,
   localparam int ADDR_W     = clog2(NUM_REGS)
) (
   input  logic                            clk,
   input  logic                            reset,
   input  logic                            issue_valid,
   input  logic [ADDR_W-1:0]               issue_rd,
   input  logic                            reg_write,
   input  logic [ADDR_W-1:0]               rd,
   input  logic [NUM_READ-1:0][ADDR_W-1:0] rs_addr,
   output logic [NUM_READ-1:0]             rs_busy
);
   localparam logic [NUM_REGS-1:0] ZERO_M = NUM_REGS'(ZERO_REG_EN);

   logic [NUM_REGS-1:0] busy, set_m, clr_m;

   always_comb begin
      set_m = '0;
      clr_m = '0;
      if (issue_valid) set_m[issue_rd] = 1'b1;
      if (reg_write)   clr_m[rd]       = 1'b1;
   end

   // Set is applied after clear: a new producer supersedes the one writing back.
   always_ff @(posedge clk) begin
      if (reset) busy <= '0;
      else       busy <= ((busy & ~clr_m) | set_m) & ~ZERO_M;
   end

   for (genvar i = 0; i < NUM_READ; i++) begin : g_busy
      assign rs_busy[i] = busy[rs_addr[i]] & ~clr_m[rs_addr[i]] & ~ZERO_M[rs_addr[i]];
   end
endmodule

// File: rtl/regfile_mp.sv
// Multi-read, single-write register file with write-before-read bypass and busy scoreboard.
module regfile_mp
   import regfile_pkg::*;
#(
   parameter int DATA_W      = REGFILE_DATA_W,
   parameter int NUM_REGS    = REGFILE_NUM_REGS,
   parameter int NUM_READ    = 2,
   parameter bit ZERO_REG_EN = 1'b1
) (
   input logic         clk,
   input logic         reset,
   regfile_mp_if.slave bus
);
   localparam int                ADDR_W = clog2(NUM_REGS);
   localparam logic [ADDR_W-1:0] ZA     = ADDR_W'(ZERO_ADDR);

   logic [NUM_REGS-1:0][DATA_W-1:0] regs;
   logic [NUM_READ-1:0][DATA_W-1:0] rdata;

   always_ff @(posedge clk) begin
      if (reset)
         regs <= '0;
      else if (bus.reg_write && !(ZERO_REG_EN && bus.rd == ZA))
         regs[bus.rd] <= bus.data_in;
   end

   // Bypass is held off during reset so the port shows what is actually stored.
   for (genvar i = 0; i < NUM_READ; i++) begin : g_rd
      logic [ADDR_W-1:0] a;
      logic              byp;
      assign a        = bus.rs_addr[i];
      assign byp      = bus.reg_write && !reset && (bus.rd == a);
      assign rdata[i] = (ZERO_REG_EN && a == ZA) ? '0 :
                        byp                      ? bus.data_in : regs[a];
   end

   assign bus.rs_data = rdata;

   regfile_scoreboard #(
      .NUM_REGS    (NUM_REGS),
      .NUM_READ    (NUM_READ),
      .ZERO_REG_EN (ZERO_REG_EN)
   ) u_sb (
      .clk         (clk),
      .reset       (reset),
      .issue_valid (bus.issue_valid),
      .issue_rd    (bus.issue_rd),
      .reg_write   (bus.reg_write),
      .rd          (bus.rd),
      .rs_addr     (bus.rs_addr),
      .rs_busy     (bus.rs_busy)
   );
endmodule

// File: tb/tb_regfile_mp.sv
// Directed and random checks of two regfile_mp builds against array-based models.
module tb_regfile_mp;
   logic clk = 1'b0;
   logic reset;
   int   errors = 0;
   int   checks = 0;

   always #5 clk = ~clk;

   regfile_mp_if #(.DATA_W(32), .NUM_REGS(32), .NUM_READ(2)) ifa ();
   regfile_mp_if #(.DATA_W(64), .NUM_REGS(16), .NUM_READ(4)) ifb ();

   regfile_mp #(.DATA_W(32), .NUM_REGS(32), .NUM_READ(2), .ZERO_REG_EN(1'b1))
      dut_a (.clk(clk), .reset(reset), .bus(ifa));
   regfile_mp #(.DATA_W(64), .NUM_REGS(16), .NUM_READ(4), .ZERO_REG_EN(1'b0))
      dut_b (.clk(clk), .reset(reset), .bus(ifb));

   logic [31:0] ma_regs[32];
   bit          ma_busy[32];
   logic [63:0] mb_regs[16];
   bit          mb_busy[16];

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] exp_da(input logic [4:0] a);
      if (a == 0) return 32'h0;
      if (ifa.reg_write && !reset && ifa.rd == a) return ifa.data_in;
      return ma_regs[a];
   endfunction

   function automatic logic exp_ba(input logic [4:0] a);
      return a != 0 && ma_busy[a] && !(ifa.reg_write && ifa.rd == a);
   endfunction

   function automatic logic [63:0] exp_db(input logic [3:0] a);
      if (ifb.reg_write && !reset && ifb.rd == a) return ifb.data_in;
      return mb_regs[a];
   endfunction

   function automatic logic exp_bb(input logic [3:0] a);
      return mb_busy[a] && !(ifb.reg_write && ifb.rd == a);
   endfunction

   task automatic check_ports();
      for (int p = 0; p < 2; p++) begin
         chk($sformatf("A.data%0d", p), 64'(ifa.rs_data[p]), 64'(exp_da(ifa.rs_addr[p])));
         chk($sformatf("A.busy%0d", p), 64'(ifa.rs_busy[p]), 64'(exp_ba(ifa.rs_addr[p])));
      end
      for (int p = 0; p < 4; p++) begin
         chk($sformatf("B.data%0d", p), ifb.rs_data[p], exp_db(ifb.rs_addr[p]));
         chk($sformatf("B.busy%0d", p), 64'(ifb.rs_busy[p]), 64'(exp_bb(ifb.rs_addr[p])));
      end
   endtask

   // Apply this cycle's inputs to the models, then advance past the edge.
   task automatic tick();
      if (reset) begin
         foreach (ma_regs[r]) begin ma_regs[r] = '0; ma_busy[r] = 0; end
         foreach (mb_regs[r]) begin mb_regs[r] = '0; mb_busy[r] = 0; end
      end else begin
         if (ifa.reg_write && ifa.rd != 0) ma_regs[ifa.rd] = ifa.data_in;
         if (ifa.reg_write)   ma_busy[ifa.rd] = 0;
         if (ifa.issue_valid) ma_busy[ifa.issue_rd] = 1;
         ma_busy[0] = 0;
         if (ifb.reg_write)   mb_regs[ifb.rd] = ifb.data_in;
         if (ifb.reg_write)   mb_busy[ifb.rd] = 0;
         if (ifb.issue_valid) mb_busy[ifb.issue_rd] = 1;
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      reset = 1'b1;
      ifa.rs_addr = '0; ifa.reg_write = 0; ifa.rd = '0; ifa.data_in = '0;
      ifa.issue_valid = 0; ifa.issue_rd = '0;
      ifb.rs_addr = '0; ifb.reg_write = 0; ifb.rd = '0; ifb.data_in = '0;
      ifb.issue_valid = 0; ifb.issue_rd = '0;
      tick();
      tick();
      reset = 1'b0;

      for (int a = 0; a < 32; a++) begin
         ifa.rs_addr[0] = 5'(a);
         ifa.rs_addr[1] = 5'(a);
         #1;
         chk("rst.data0", 64'(ifa.rs_data[0]), 64'h0);
         chk("rst.data1", 64'(ifa.rs_data[1]), 64'h0);
         chk("rst.busy0", 64'(ifa.rs_busy[0]), 64'h0);
         chk("rst.busy1", 64'(ifa.rs_busy[1]), 64'h0);
      end

      ifa.reg_write = 1; ifa.rd = 5'd5; ifa.data_in = 32'hDEADBEEF;
      tick();
      ifa.reg_write = 0; ifa.rs_addr[0] = 5'd5;
      #1 chk("x5.read", 64'(ifa.rs_data[0]), 64'hDEADBEEF);

      ifa.reg_write = 1; ifa.rd = 5'd0; ifa.data_in = 32'h1234; ifa.rs_addr[0] = 5'd0;
      #1 chk("x0.bypass", 64'(ifa.rs_data[0]), 64'h0);
      tick();
      ifa.reg_write = 0;
      #1 chk("x0.read", 64'(ifa.rs_data[0]), 64'h0);

      ifa.reg_write = 1; ifa.rd = 5'd7; ifa.data_in = 32'hA5A5A5A5;
      ifa.rs_addr[0] = 5'd7; ifa.rs_addr[1] = 5'd7;
      #1;
      chk("byp.port0", 64'(ifa.rs_data[0]), 64'hA5A5A5A5);
      chk("byp.port1", 64'(ifa.rs_data[1]), 64'hA5A5A5A5);
      tick();
      ifa.reg_write = 0;

      ifa.issue_valid = 1; ifa.issue_rd = 5'd9;
      tick();
      ifa.issue_valid = 0; ifa.rs_addr[0] = 5'd9;
      #1 chk("x9.busy", 64'(ifa.rs_busy[0]), 64'h1);
      ifa.reg_write = 1; ifa.rd = 5'd9; ifa.data_in = 32'h99;
      #1;
      chk("x9.wb_busy", 64'(ifa.rs_busy[0]), 64'h0);
      chk("x9.wb_data", 64'(ifa.rs_data[0]), 64'h99);
      tick();
      ifa.reg_write = 0;
      #1 chk("x9.after_wb", 64'(ifa.rs_busy[0]), 64'h0);
      ifa.reg_write = 1; ifa.issue_valid = 1; ifa.issue_rd = 5'd9;
      tick();
      ifa.reg_write = 0; ifa.issue_valid = 0;
      #1 chk("x9.set_wins", 64'(ifa.rs_busy[0]), 64'h1);
      check_ports();

      ifa.reg_write = 1; ifa.rd = 5'd3; ifa.data_in = 32'h55;
      tick();
      ifa.reg_write = 0; ifa.issue_valid = 1; ifa.issue_rd = 5'd3;
      tick();
      ifa.issue_valid = 0; ifa.rs_addr[1] = 5'd3;
      #1 chk("x3.busy", 64'(ifa.rs_busy[1]), 64'h1);
      reset = 1;
      ifa.reg_write = 1; ifa.rd = 5'd4; ifa.data_in = 32'hCAFE; ifa.rs_addr[0] = 5'd4;
      #1 chk("rst.no_bypass", 64'(ifa.rs_data[0]), 64'h0);
      tick();
      reset = 0; ifa.reg_write = 0;
      #1;
      chk("rst.x3_data", 64'(ifa.rs_data[1]), 64'h0);
      chk("rst.x3_busy", 64'(ifa.rs_busy[1]), 64'h0);
      chk("rst.x4_data", 64'(ifa.rs_data[0]), 64'h0);
      ifa.rs_addr[0] = 5'd9;
      #1 chk("rst.x9_busy", 64'(ifa.rs_busy[0]), 64'h0);

      ifb.reg_write = 1; ifb.rd = 4'd0; ifb.data_in = 64'hFFFF_FFFF_FFFF_FFFF;
      tick();
      ifb.reg_write = 0; ifb.rs_addr = '0;
      #1;
      for (int p = 0; p < 4; p++)
         chk($sformatf("B.x0.port%0d", p), ifb.rs_data[p], 64'hFFFF_FFFF_FFFF_FFFF);
      check_ports();

      for (int n = 0; n < 1000; n++) begin
         reset           = ($urandom_range(0, 63) == 0);
         ifa.reg_write   = 1'($urandom_range(0, 1));
         ifa.rd          = 5'($urandom);
         ifa.data_in     = $urandom;
         ifa.issue_valid = 1'($urandom_range(0, 1));
         ifa.issue_rd    = 5'($urandom);
         for (int p = 0; p < 2; p++)
            ifa.rs_addr[p] = ($urandom_range(0, 3) == 0) ? ifa.rd : 5'($urandom);
         ifb.reg_write   = 1'($urandom_range(0, 1));
         ifb.rd          = 4'($urandom);
         ifb.data_in     = {$urandom, $urandom};
         ifb.issue_valid = 1'($urandom_range(0, 1));
         ifb.issue_rd    = 4'($urandom);
         for (int p = 0; p < 4; p++)
            ifb.rs_addr[p] = ($urandom_range(0, 3) == 0) ? ifb.rd : 4'($urandom);
         #1 check_ports();
         tick();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
